// File: rtl/variable_pkg.sv
// Shared playfield geometry, fixed-point types and controller enums for throw_ctl
// and the projectile/HUD draw stages.
package variable_pkg;

    localparam int POS_W = 13;
    localparam int VEL_W = 8;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0] vel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FLIGHT = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HIT_NONE   = 2'd0,
        HIT_FENCE  = 2'd1,
        HIT_TARGET = 2'd2,
        HIT_OUT    = 2'd3
    } hit_t;

    localparam pos_t SCREEN_X_MAX = 13'sd1023;

    localparam pos_t FENCE_X0 = 13'sd497;
    localparam pos_t FENCE_X1 = 13'sd527;
    localparam pos_t FENCE_Y0 = 13'sd384;
    localparam pos_t FENCE_Y1 = 13'sd743;

    localparam pos_t GROUND_Y = 13'sd669;

    localparam pos_t CAT_BOX_X0 = 13'sd100;
    localparam pos_t CAT_BOX_X1 = 13'sd163;
    localparam pos_t DOG_BOX_X0 = 13'sd860;
    localparam pos_t DOG_BOX_X1 = 13'sd923;
    localparam pos_t BOX_Y0     = 13'sd605;
    localparam pos_t BOX_Y1     = 13'sd668;

    localparam pos_t CAT_LAUNCH_X = 13'sd164;
    localparam pos_t DOG_LAUNCH_X = 13'sd859;
    localparam pos_t LAUNCH_Y     = 13'sd600;

    function automatic logic in_box(input pos_t x, input pos_t y,
                                    input pos_t x0, input pos_t x1,
                                    input pos_t y0, input pos_t y1);
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

endpackage

// File: rtl/throw_physics.sv
// One ballistic step of the projectile plus classification of what the new
// position collides with; purely combinational.
module throw_physics
    import variable_pkg::*;
#(
    parameter int GRAVITY = 1
) (
    input  pos_t       x,
    input  pos_t       y,
    input  vel_t       vx,
    input  vel_t       vy,
    input  logic       turn,
    output pos_t       nx,
    output pos_t       ny,
    output vel_t       nvy,
    output hit_t       hit
);

    localparam vel_t GRAV_V = vel_t'(GRAVITY);

    logic opp_box;
    logic out_of_play;

    assign nx  = x + {{(POS_W-VEL_W){vx[VEL_W-1]}}, vx};
    assign ny  = y + {{(POS_W-VEL_W){vy[VEL_W-1]}}, vy};
    assign nvy = vy + GRAV_V;

    // The thrower's own box is never a target: the cat aims at the dog and vice versa.
    assign opp_box = turn ? in_box(nx, ny, CAT_BOX_X0, CAT_BOX_X1, BOX_Y0, BOX_Y1)
                          : in_box(nx, ny, DOG_BOX_X0, DOG_BOX_X1, BOX_Y0, BOX_Y1);

    // Leaving through the top is allowed; only ground and the side edges end a throw.
    assign out_of_play = (ny >= GROUND_Y) || nx[POS_W-1] || (nx > SCREEN_X_MAX);

    always_comb begin
        hit = HIT_NONE;
        if (in_box(nx, ny, FENCE_X0, FENCE_X1, FENCE_Y0, FENCE_Y1)) begin
            hit = HIT_FENCE;
        end else if (opp_box) begin
            hit = HIT_TARGET;
        end else if (out_of_play) begin
            hit = HIT_OUT;
        end
    end

endmodule

// File: rtl/throw_ctl.sv
// Turn, power-charge and flight controller for the cat-vs-dog throwing game,
// paced by the rising edge of vblnk. Optional scoring: define THROW_SCORE_EN.
module throw_ctl
    import variable_pkg::*;
#(
    parameter int PWR_MAX     = 63,
    parameter int GRAVITY     = 1,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        fire_cat,
    input  logic        fire_dog,
    output logic        turn,
    output logic [1:0]  state,
    output logic [5:0]  power,
    output logic        proj_active,
    output logic [10:0] proj_x,
    output logic [10:0] proj_y,
    output logic        hit_cat,
    output logic        hit_dog,
    output logic        fence_hit
`ifdef THROW_SCORE_EN
    ,
    output logic [3:0]  score_cat,
    output logic [3:0]  score_dog
`endif
);

    localparam int             HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [5:0]     PWR_SAT   = 6'(PWR_MAX);

    logic              vblnk_q;
    state_t            state_q,     state_d;
    logic              turn_q,      turn_d;
    logic [5:0]        power_q,     power_d;
    pos_t              pos_x_q,     pos_x_d;
    pos_t              pos_y_q,     pos_y_d;
    vel_t              vx_q,        vx_d;
    vel_t              vy_q,        vy_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic              active_q,    active_d;
    logic              hit_cat_q,   hit_cat_d;
    logic              hit_dog_q,   hit_dog_d;
    logic              fence_q,     fence_d;

    logic tick;
    logic fire_act;
    logic halt;
    vel_t vx_mag;
    pos_t phys_nx;
    pos_t phys_ny;
    vel_t phys_nvy;
    hit_t phys_hit;

    assign tick     = vblnk & ~vblnk_q;
    assign fire_act = turn_q ? fire_dog : fire_cat;
    assign vx_mag   = vel_t'({3'b000, power_q[5:1]});

    throw_physics #(
        .GRAVITY (GRAVITY)
    ) u_physics (
        .x    (pos_x_q),
        .y    (pos_y_q),
        .vx   (vx_q),
        .vy   (vy_q),
        .turn (turn_q),
        .nx   (phys_nx),
        .ny   (phys_ny),
        .nvy  (phys_nvy),
        .hit  (phys_hit)
    );

`ifdef THROW_SCORE_EN
    logic [3:0] score_cat_q, score_cat_d;
    logic [3:0] score_dog_q, score_dog_d;

    // Once either side reaches 9 the game is over and RESULT never releases.
    assign halt = (score_cat_q == 4'd9) || (score_dog_q == 4'd9);

    always_comb begin
        score_cat_d = score_cat_q;
        score_dog_d = score_dog_q;
        if (hit_cat_d && score_cat_q != 4'd9) begin
            score_cat_d = score_cat_q + 4'd1;
        end
        if (hit_dog_d && score_dog_q != 4'd9) begin
            score_dog_d = score_dog_q + 4'd1;
        end
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            score_cat_q <= 4'd0;
            score_dog_q <= 4'd0;
        end else begin
            score_cat_q <= score_cat_d;
            score_dog_q <= score_dog_d;
        end
    end

    assign score_cat = score_cat_q;
    assign score_dog = score_dog_q;
`else
    assign halt = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        power_d   = power_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        hold_d    = hold_q;
        active_d  = active_q;
        hit_cat_d = 1'b0;
        hit_dog_d = 1'b0;
        fence_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire_act) begin
                    state_d = ST_CHARGE;
                    power_d = 6'd1;
                end
            end
            ST_CHARGE: begin
                // Release wins over a coincident tick, so the last increment is dropped.
                if (!fire_act) begin
                    state_d  = ST_FLIGHT;
                    vx_d     = turn_q ? -vx_mag : vx_mag;
                    vy_d     = -vel_t'({2'b00, power_q});
                    pos_x_d  = turn_q ? DOG_LAUNCH_X : CAT_LAUNCH_X;
                    pos_y_d  = LAUNCH_Y;
                    active_d = 1'b1;
                end else if (tick && power_q != PWR_SAT) begin
                    power_d = power_q + 6'd1;
                end
            end
            ST_FLIGHT: begin
                if (tick) begin
                    pos_x_d = phys_nx;
                    pos_y_d = phys_ny;
                    vy_d    = phys_nvy;
                    if (phys_hit != HIT_NONE) begin
                        state_d   = ST_RESULT;
                        active_d  = 1'b0;
                        hold_d    = '0;
                        fence_d   = (phys_hit == HIT_FENCE);
                        hit_dog_d = (phys_hit == HIT_TARGET) && !turn_q;
                        hit_cat_d = (phys_hit == HIT_TARGET) && turn_q;
                    end
                end
            end
            ST_RESULT: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        if (!halt) begin
                            state_d = ST_IDLE;
                            turn_d  = ~turn_q;
                            hold_d  = '0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q   <= 1'b0;
            state_q   <= ST_IDLE;
            turn_q    <= 1'b0;
            power_q   <= 6'd0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            hold_q    <= '0;
            active_q  <= 1'b0;
            hit_cat_q <= 1'b0;
            hit_dog_q <= 1'b0;
            fence_q   <= 1'b0;
        end else begin
            vblnk_q   <= vblnk;
            state_q   <= state_d;
            turn_q    <= turn_d;
            power_q   <= power_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            hold_q    <= hold_d;
            active_q  <= active_d;
            hit_cat_q <= hit_cat_d;
            hit_dog_q <= hit_dog_d;
            fence_q   <= fence_d;
        end
    end

    assign turn        = turn_q;
    assign state       = state_q;
    assign power       = power_q;
    assign proj_active = active_q;
    assign proj_x      = pos_x_q[10:0];
    assign proj_y      = pos_y_q[10:0];
    assign hit_cat     = hit_cat_q;
    assign hit_dog     = hit_dog_q;
    assign fence_hit   = fence_q;

endmodule

// File: doc/throw_ctl.md
# throw_ctl

Turn and trajectory controller for the cat-vs-dog throwing game. Each frame it decides which player owns the turn, charges throw power while the active player holds fire, and steps the projectile along a ballistic path over the fence. It reports each result as hit, fence or ground. It sits beside the background/sprite drawing chain: its registered position and state outputs feed the projectile and HUD draw stages, and it samples the timing generator's vertical blanking to pace itself at frame rate.

## Interface
- `PWR_MAX`, 63: saturation value of the power counter.
- `GRAVITY`, 1: added to vertical velocity every frame.
- `HOLD_FRAMES`, 60: frames spent in RESULT before the turn passes.
- `clk60MHz` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `vblnk` in 1: vertical blanking from the timing chain. Its rising edge is the frame tick.
- `fire_cat` in 1: cat fire button, debounced and synchronous to `clk60MHz`.
- `fire_dog` in 1: dog fire button, same conditioning.
- `turn` out 1: 0 = cat throws, 1 = dog throws.
- `state` out 2: 0 IDLE, 1 CHARGE, 2 FLIGHT, 3 RESULT.
- `power` out 6: current charge level.
- `proj_active` out 1: projectile visible.
- `proj_x` out 11: projectile x in pixels.
- `proj_y` out 11: projectile y in pixels.
- `hit_cat` out 1: one-cycle pulse when the dog hits the cat.
- `hit_dog` out 1: one-cycle pulse when the cat hits the dog.
- `fence_hit` out 1: one-cycle pulse when the projectile strikes the fence.

## Operation
- Frame tick `tick` = `vblnk & ~vblnk_q`. The registered delay `vblnk_q` resets to 0.
- Screen is 1024×768.
- Fence box: x 497..527, y 384..743.
- Ground: y ≥ 669.
- Cat target box: x 100..163, y 605..668. Dog target box: x 860..923, y 605..668.
- Launch points: cat (164,600), dog (859,600).
- Only the fire input of the `turn` player is observed. The other player's button is ignored in every state.
- IDLE → CHARGE on the cycle the active fire button is seen high. `power` loads 1.
- CHARGE, on each tick while the button is held: `power` increments, saturating at `PWR_MAX`.
- CHARGE → FLIGHT on the first cycle the button is low:
  - vx = power>>1, negated for the dog.
  - vy = −power.
  - Position = the player's launch point; `proj_active` = 1.
- FLIGHT, per tick:
  - x += vx, y += vy, vy += GRAVITY.
  - Internal position is 13-bit signed; velocities are 8-bit signed; all arithmetic is sign-extended.
  - Collision is checked on the new position, in priority order:
    1. Fence: pulse `fence_hit`.
    2. Opponent box: pulse `hit_dog` or `hit_cat`.
    3. Ground, x < 0, or x > 1023: no pulse.
  - Any collision → RESULT, `proj_active` = 0.
  - A projectile above the top of the screen (y < 0) keeps flying.
  - `proj_x`/`proj_y` are the low 11 bits of the internal position and are meaningful only while `proj_active` = 1.
- RESULT: counts `HOLD_FRAMES` ticks, then → IDLE with `turn` toggled.
- Reset values:
  - `turn` = 0, `state` = IDLE.
  - `power`, `proj_x`, `proj_y`, velocities, hold counter: all 0.
  - All pulses = 0, `proj_active` = 0.
  - Asserting `rst_n` low mid-flight aborts immediately to these values.

## Timing
- All outputs are registered.
- Position changes on the cycle after `tick`. Collision pulses assert on that same cycle, for exactly one cycle.
- IDLE→CHARGE and CHARGE→FLIGHT take 1 cycle after the button edge, not tick-aligned.
- A tick on the same cycle as the CHARGE→FLIGHT transition does not move the projectile. The first step happens on the next tick.
- A tick and a button press on the same cycle in IDLE: enter CHARGE with `power` = 1. Do not also increment.
- A release on a tick cycle in CHARGE: leave CHARGE; that tick's increment is discarded.

## Configuration
- `THROW_SCORE_EN` defined:
  - Adds outputs `score_cat` and `score_dog`, 4 bits each, reset 0.
  - A score increments on the cycle the corresponding hit pulse asserts, saturating at 9.
  - When a score reaches 9, the block holds in RESULT until reset.
- Undefined: no score ports and no score logic. The game alternates turns indefinitely.

## Structure
- `variable_pkg` holds:
  - The state enum.
  - Fence, ground, target-box and launch-point constants, shared with the drawing stages.
- Sub-module `throw_physics`: combinational next-position/velocity and collision classification. It returns next x/y/vy and a 2-bit hit code.
- The FSM, counters and tick detector stay in `throw_ctl`.

## Test plan
1. Reset, then cat presses fire and releases after 10 ticks → `power` = 11, vx = 5, vy = −11, first tick gives `proj_x` = 169, `proj_y` = 589.
2. Cat holds fire for 100 ticks → `power` saturates at 63 and does not wrap.
3. Trajectory forced into x 497..527 at y ≥ 384 → `fence_hit` pulses 1 cycle, state = RESULT, `proj_active` = 0. After 60 ticks, state = IDLE and `turn` = 1.
4. Dog's turn with `fire_cat` toggling → no state change. Dog throw landing in x 100..163, y 605..668 → `hit_cat` pulses once.
5. `rst_n` pulsed low mid-FLIGHT, asynchronously between clock edges → all outputs at reset values immediately, `turn` = 0.
6. `THROW_SCORE_EN`: nine cat hits → `score_dog` = 9, and the block stays in RESULT indefinitely.
